// File: rtl/cr16_alu_sequencer.sv
// rtl/cr16_alu_sequencer.sv - CR16 instruction sequencer driving an external ALU
// One instruction at a time through IDLE/READ/EXEC/WB with a 16x16 register file and PSR.
module cr16_alu_sequencer (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_INSTR_VALID,
  input  logic [15:0] I_INSTR,
  output logic        O_INSTR_READY,
  output logic        O_ALU_ENABLE,
  output logic [3:0]  O_ALU_OPCODE,
  output logic [15:0] O_ALU_A,
  output logic [15:0] O_ALU_B,
  input  logic [15:0] I_ALU_C,
  input  logic [4:0]  I_ALU_STATUS,
  output logic [4:0]  O_PSR,
  output logic        O_DONE,
  output logic        O_ERR,
  input  logic [3:0]  I_DBG_ADDR,
  output logic [15:0] O_DBG_DATA
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, rd_q, rs_q;
  logic [3:0]  alu_op_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic [4:0]  psr_q;
  logic [15:0] rf_q [16];

  logic handshake, illegal, shift_op, psr_op;
  logic unused_instr_bits;

  assign handshake         = I_INSTR_VALID && (state_q == S_IDLE);
  assign illegal           = (op_q[3:1] == 3'b111);
  assign shift_op          = (op_q >= 4'd10);
  assign psr_op            = (op_q <= 4'd5);
  assign unused_instr_bits = ^I_INSTR[3:0];

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (handshake) state_d = S_READ;
      S_READ:  state_d = illegal ? S_IDLE : S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    O_INSTR_READY = (state_q == S_IDLE);
    O_ALU_ENABLE  = (state_q == S_EXEC);
    O_DONE        = (state_q == S_WB);
    O_ERR         = (state_q == S_READ) && illegal;
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
    end else if (handshake) begin
      op_q <= I_INSTR[15:12];
      rd_q <= I_INSTR[11:8];
      rs_q <= I_INSTR[7:4];
    end
  end

  // Shifts take the destination as the shifted value; everything else puts Rsrc on A.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else if ((state_q == S_READ) && !illegal) begin
      alu_op_q <= op_q;
      alu_a_q  <= shift_op ? rf_q[rd_q] : rf_q[rs_q];
      alu_b_q  <= shift_op ? rf_q[rs_q] : rf_q[rd_q];
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      psr_q <= '0;
    end else if (state_q == S_WB) begin
      rf_q[rd_q] <= I_ALU_C;
      if (psr_op) psr_q <= I_ALU_STATUS;
    end
  end

  assign O_ALU_OPCODE = alu_op_q;
  assign O_ALU_A      = alu_a_q;
  assign O_ALU_B      = alu_b_q;
  assign O_PSR        = psr_q;
  assign O_DBG_DATA   = rf_q[I_DBG_ADDR];

endmodule

// File: tb/tb_cr16_alu_sequencer.sv
// tb/tb_cr16_alu_sequencer.sv - scoreboard bench for cr16_alu_sequencer
// Stimulus pushes expected results; a negedge monitor pops them on O_DONE/O_ERR.
module tb_cr16_alu_sequencer;

  logic        I_CLK = 1'b0;
  logic        I_RESET = 1'b1;
  logic        I_INSTR_VALID = 1'b0;
  logic [15:0] I_INSTR = '0;
  logic        O_INSTR_READY, O_ALU_ENABLE, O_DONE, O_ERR;
  logic [3:0]  O_ALU_OPCODE;
  logic [15:0] O_ALU_A, O_ALU_B, O_DBG_DATA;
  logic [15:0] I_ALU_C;
  logic [4:0]  I_ALU_STATUS, O_PSR;
  logic [3:0]  I_DBG_ADDR;

  cr16_alu_sequencer dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_INSTR_VALID(I_INSTR_VALID), .I_INSTR(I_INSTR),
    .O_INSTR_READY(O_INSTR_READY), .O_ALU_ENABLE(O_ALU_ENABLE), .O_ALU_OPCODE(O_ALU_OPCODE),
    .O_ALU_A(O_ALU_A), .O_ALU_B(O_ALU_B), .I_ALU_C(I_ALU_C), .I_ALU_STATUS(I_ALU_STATUS),
    .O_PSR(O_PSR), .O_DONE(O_DONE), .O_ERR(O_ERR), .I_DBG_ADDR(I_DBG_ADDR), .O_DBG_DATA(O_DBG_DATA)
  );

  always #5 I_CLK = ~I_CLK;

  int cyc = 0;
  always @(posedge I_CLK) cyc <= cyc + 1;

  // Bench ALU: ADDC/ADDCU use a fixed carry-in of 1 so registers can be preloaded by increments.
  logic [16:0] sum;
  logic        carry;
  always_comb begin
    sum = '0; carry = 1'b0; I_ALU_C = '0;
    case (O_ALU_OPCODE)
      4'd0, 4'd1: begin sum = {1'b0, O_ALU_A} + {1'b0, O_ALU_B}; I_ALU_C = sum[15:0]; carry = sum[16]; end
      4'd2, 4'd3: begin sum = {1'b0, O_ALU_A} + {1'b0, O_ALU_B} + 17'd1; I_ALU_C = sum[15:0]; carry = sum[16]; end
      4'd4, 4'd5: begin I_ALU_C = O_ALU_B - O_ALU_A; carry = (O_ALU_A > O_ALU_B); end
      4'd6:  I_ALU_C = O_ALU_A & O_ALU_B;
      4'd7:  I_ALU_C = O_ALU_A | O_ALU_B;
      4'd8:  I_ALU_C = O_ALU_A ^ O_ALU_B;
      4'd9:  I_ALU_C = ~O_ALU_A;
      4'd10, 4'd12: I_ALU_C = O_ALU_A << O_ALU_B[3:0];
      4'd11: I_ALU_C = O_ALU_A >> O_ALU_B[3:0];
      4'd13: I_ALU_C = 16'($signed(O_ALU_A) >>> O_ALU_B[3:0]);
      default: I_ALU_C = '0;
    endcase
  end
  assign I_ALU_STATUS = {I_ALU_C[15], (I_ALU_C == 16'd0), 1'b0, 1'b0, carry};

  typedef struct packed {
    logic        is_err;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] old_v;
    logic [15:0] new_v;
    logic [4:0]  psr;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic       mon_active = 1'b0;
  logic [3:0] mon_addr = '0;
  logic [3:0] main_addr = '0;
  assign I_DBG_ADDR = mon_active ? mon_addr : main_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic is_err, input logic [3:0] op, input logic [3:0] rd,
                              input logic [15:0] a, input logic [15:0] b, input logic [15:0] old_v,
                              input logic [15:0] new_v, input logic [4:0] psr);
    exp_t e;
    e = '{is_err: is_err, op: op, rd: rd, a: a, b: b, old_v: old_v, new_v: new_v, psr: psr, cyc: '0};
    return e;
  endfunction

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs);
    return {op, rd, rs, 4'hA};
  endfunction

  task automatic issue(input logic [15:0] ins, input exp_t e, input bit track);
    bit ok;
    ok = 1'b0;
    @(negedge I_CLK);
    I_INSTR_VALID = 1'b1;
    I_INSTR = ins;
    for (int t = 0; t < 20; t++) begin
      if (O_INSTR_READY) begin
        if (track) begin
          e.cyc = cyc + (e.is_err ? 1 : 3);
          sb.push_back(e);
        end
        ok = 1'b1;
        break;
      end
      @(negedge I_CLK);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got ready=0 expected ready=1 within 20 cycles");
    end else begin
      @(posedge I_CLK);
      #1;
    end
    I_INSTR_VALID = 1'b0;
  endtask

  task automatic dbg_chk(input string name, input logic [3:0] addr, input logic [15:0] exp);
    main_addr = addr;
    #1;
    chk(name, 32'(O_DBG_DATA), 32'(exp));
  endtask

  task automatic preload(input logic [3:0] rd, input int n);
    for (int k = 1; k <= n; k++)
      issue(enc(4'd2, rd, 4'd0), mk(1'b0, 4'd2, rd, 16'd0, 16'(k - 1), 16'(k - 1), 16'(k), 5'b00000), 1'b1);
  endtask

  exp_t me;
  initial begin
    forever begin
      @(negedge I_CLK);
      if (O_DONE || O_ERR) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_response: got done=%0b err=%0b expected none", O_DONE, O_ERR);
        end else begin
          me = sb.pop_front();
          chk("resp_kind_err", 32'(O_ERR), 32'(me.is_err));
          chk("resp_cycle", 32'(cyc), me.cyc);
          if (!me.is_err) begin
            chk("alu_opcode", 32'(O_ALU_OPCODE), 32'(me.op));
            chk("alu_a", 32'(O_ALU_A), 32'(me.a));
            chk("alu_b", 32'(O_ALU_B), 32'(me.b));
            mon_addr = me.rd;
            mon_active = 1'b1;
            #1;
            chk("wb_old_value", 32'(O_DBG_DATA), 32'(me.old_v));
            @(negedge I_CLK);
            chk("wb_new_value", 32'(O_DBG_DATA), 32'(me.new_v));
            chk("psr_after_wb", 32'(O_PSR), 32'(me.psr));
            chk("ready_after_wb", 32'(O_INSTR_READY), 32'd1);
            mon_active = 1'b0;
          end else begin
            chk("err_alu_enable", 32'(O_ALU_ENABLE), 32'd0);
            chk("err_psr", 32'(O_PSR), 32'(me.psr));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  int hs_cycles[$];
  initial begin
    // Reset state, checked while reset is still asserted and after release.
    #3;
    chk("rst_alu_enable", 32'(O_ALU_ENABLE), 32'd0);
    chk("rst_alu_opcode", 32'(O_ALU_OPCODE), 32'd0);
    chk("rst_alu_a", 32'(O_ALU_A), 32'd0);
    chk("rst_alu_b", 32'(O_ALU_B), 32'd0);
    chk("rst_done", 32'(O_DONE), 32'd0);
    chk("rst_err", 32'(O_ERR), 32'd0);
    chk("rst_psr", 32'(O_PSR), 32'd0);
    repeat (2) @(negedge I_CLK);
    I_RESET = 1'b0;
    #1;
    chk("rst_ready", 32'(O_INSTR_READY), 32'd1);
    for (int r = 0; r < 16; r++) dbg_chk("rst_reg", 4'(r), 16'd0);

    // ADD R1,R1 on zeros: ALU reports Z only.
    issue(enc(4'd0, 4'd1, 4'd1), mk(1'b0, 4'd0, 4'd1, 16'd0, 16'd0, 16'd0, 16'd0, 5'b01000), 1'b1);

    preload(4'd4, 1);
    preload(4'd5, 3);
    preload(4'd2, 5);
    preload(4'd3, 7);

    // SUB R2,R3: 5 - 7 wraps to 0xFFFE with N and borrow.
    issue(enc(4'd4, 4'd2, 4'd3), mk(1'b0, 4'd4, 4'd2, 16'd7, 16'd5, 16'd5, 16'hFFFE, 5'b10001), 1'b1);
    // LSH R4,R5: 1 << 3, PSR kept from the SUB.
    issue(enc(4'd10, 4'd4, 4'd5), mk(1'b0, 4'd10, 4'd4, 16'd1, 16'd3, 16'd1, 16'd8, 5'b10001), 1'b1);

    // Illegal op 15: ERR in READ, ready back the cycle after.
    issue(enc(4'd15, 4'd2, 4'd3), mk(1'b1, 4'd15, 4'd2, 16'd0, 16'd0, 16'd0, 16'd0, 5'b10001), 1'b1);
    @(negedge I_CLK);
    chk("illegal_ready_in_read", 32'(O_INSTR_READY), 32'd0);
    @(negedge I_CLK);
    chk("illegal_ready_after", 32'(O_INSTR_READY), 32'd1);
    chk("illegal_psr", 32'(O_PSR), 32'h11);
    dbg_chk("illegal_r2_kept", 4'd2, 16'hFFFE);
    dbg_chk("illegal_r3_kept", 4'd3, 16'd7);

    // rdest == rsrc: ADD R5,R5 reads the pre-write value on both operands.
    issue(enc(4'd0, 4'd5, 4'd5), mk(1'b0, 4'd0, 4'd5, 16'd3, 16'd3, 16'd3, 16'd6, 5'b00000), 1'b1);
    repeat (6) @(negedge I_CLK);

    // Reset during EXEC of ADD R6,R7 aborts it.
    issue(enc(4'd0, 4'd6, 4'd7), mk(1'b0, 4'd0, 4'd6, 16'd0, 16'd0, 16'd0, 16'd0, 5'b01000), 1'b0);
    @(negedge I_CLK);
    @(negedge I_CLK);
    chk("exec_enable", 32'(O_ALU_ENABLE), 32'd1);
    I_RESET = 1'b1;
    #1;
    chk("abort_enable", 32'(O_ALU_ENABLE), 32'd0);
    chk("abort_alu_a", 32'(O_ALU_A), 32'd0);
    chk("abort_alu_opcode", 32'(O_ALU_OPCODE), 32'd0);
    chk("abort_psr", 32'(O_PSR), 32'd0);
    chk("abort_done", 32'(O_DONE), 32'd0);
    repeat (2) @(negedge I_CLK);
    I_RESET = 1'b0;
    #1;
    chk("abort_ready", 32'(O_INSTR_READY), 32'd1);
    dbg_chk("abort_r6", 4'd6, 16'd0);
    dbg_chk("abort_r2_cleared", 4'd2, 16'd0);

    // VALID held for 10 cycles with a new instruction each cycle.
    for (int c = 0; c < 10; c++) begin
      I_INSTR_VALID = 1'b1;
      I_INSTR = enc(4'd2, 4'(6 + c), 4'd0);
      if (O_INSTR_READY) begin
        me = mk(1'b0, 4'd2, 4'(6 + c), 16'd0, 16'd0, 16'd0, 16'd1, 5'b00000);
        me.cyc = cyc + 3;
        sb.push_back(me);
        hs_cycles.push_back(c);
      end
      @(negedge I_CLK);
    end
    I_INSTR_VALID = 1'b0;
    chk("handshake_count", 32'(hs_cycles.size()), 32'd3);
    if (hs_cycles.size() == 3) begin
      chk("handshake_cycle0", 32'(hs_cycles[0]), 32'd0);
      chk("handshake_cycle1", 32'(hs_cycles[1]), 32'd4);
      chk("handshake_cycle2", 32'(hs_cycles[2]), 32'd8);
    end

    repeat (8) @(negedge I_CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    dbg_chk("stream_r7_untouched", 4'd7, 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cr16_alu_sequencer.md
CR16_ALU_SEQUENCER -- requirements
Module: cr16_alu_sequencer

Interface
REQ-001 SHALL have no parameters; 16-bit datapath, 16-entry register file and 4-bit opcodes are fixed.
REQ-002 SHALL have ports (name, direction, width, meaning):
- I_CLK  in  1  single clock; all state on rising edge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_INSTR_VALID  in  1  instruction offered.
- I_INSTR  in  16  [15:12] op, [11:8] rdest, [7:4] rsrc, [3:0] ignored.
- O_INSTR_READY  out  1  sequencer can accept an instruction.
- O_ALU_ENABLE  out  1  ALU enable.
- O_ALU_OPCODE  out  4  ALU opcode.
- O_ALU_A  out  16  ALU operand A.
- O_ALU_B  out  16  ALU operand B.
- I_ALU_C  in  16  ALU result.
- I_ALU_STATUS  in  5  ALU flags: [4]N [3]Z [2]F [1]L [0]C.
- O_PSR  out  5  latched flags, same bit order.
- O_DONE  out  1  one-cycle pulse at writeback.
- O_ERR  out  1  one-cycle pulse on illegal opcode.
- I_DBG_ADDR  in  4  debug register select.
- O_DBG_DATA  out  16  combinational read of R[I_DBG_ADDR].

Function
REQ-003 SHALL implement the FSM IDLE -> READ -> EXEC -> WB -> IDLE. It SHALL leave IDLE only on a handshake.
REQ-004 A handshake SHALL occur on a rising edge with I_INSTR_VALID=1 and O_INSTR_READY=1. The instruction SHALL be latched on that edge.
REQ-005 O_INSTR_READY SHALL be 1 only in IDLE. I_INSTR_VALID in any other state SHALL be ignored, with no queuing.
REQ-006 In READ, the sequencer SHALL register both operands from the register file and the opcode.
REQ-007 In EXEC, O_ALU_ENABLE SHALL be 1 and O_ALU_OPCODE/A/B SHALL be stable. In all other states, O_ALU_ENABLE SHALL be 0 and the ALU outputs SHALL hold their last values.
REQ-008 Operand mapping for ops 0-9 SHALL be A=R[rsrc], B=R[rdest], giving SUB/SUBU = Rdest-Rsrc and NOT = ~Rsrc.
REQ-009 Operand mapping for ops 10-13 (LSH, RSH, ALSH, ARSH) SHALL be A=R[rdest], B=R[rsrc], so Rdest is shifted by Rsrc.
REQ-010 In WB, I_ALU_C SHALL be written to R[rdest] on the WB edge, and O_DONE SHALL be 1 for that cycle.
REQ-011 PSR update SHALL apply only to ops 0-5 (ADD, ADDU, ADDC, ADDCU, SUB, SUBU): PSR <= I_ALU_STATUS at WB. Ops 6-13 SHALL leave PSR unchanged.
REQ-012 Ops 14 and 15 are illegal and SHALL follow IDLE -> READ -> IDLE:
- O_ERR pulses 1 cycle in READ.
- O_ALU_ENABLE stays 0.
- No register write, no PSR change, no O_DONE.
REQ-013 Latency for legal ops, with the handshake at edge N:
- READ in cycle N+1, EXEC in N+2, WB in N+3.
- Result visible in the register file after edge N+4.
- O_INSTR_READY returns high in cycle N+4.
- Back-to-back throughput is one instruction per 4 cycles.
REQ-014 rdest == rsrc SHALL be legal. Both operands SHALL read the pre-write value.
REQ-015 A debug read of the register being written in WB SHALL return the old value until the WB edge, then the new value.
REQ-016 Register file values SHALL wrap modulo 2^16; the sequencer SHALL perform no arithmetic of its own.

Reset
REQ-017 While I_RESET=1, regardless of clock, the sequencer SHALL:
- enter IDLE and clear all 16 registers and PSR to 0;
- drive O_ALU_ENABLE=0, O_ALU_OPCODE=0, O_ALU_A=0, O_ALU_B=0;
- drive O_DONE=0 and O_ERR=0;
- drive O_INSTR_READY=1 once reset is released.
REQ-018 Reset asserted in READ, EXEC or WB SHALL abort the instruction with no register write and no PSR update. The first edge after release SHALL accept a handshake.

Verification
REQ-019 Reset, then ADD R1,R1: R1=0, PSR=5'b01000 returned by the ALU model -> O_DONE at N+3, PSR=01000, R1=0.
REQ-020 Preload via ADDC chain, then SUB with R2=5, R3=7, instr op=4 rdest=2 rsrc=3 -> O_ALU_A=7, O_ALU_B=5 in EXEC; R2=0xFFFE; PSR=ALU status.
REQ-021 LSH with R4=0x0001, R5=3, op=10 rdest=4 rsrc=5 -> O_ALU_A=1, O_ALU_B=3; R4=0x0008; PSR unchanged from the prior value.
REQ-022 op=15 -> O_ERR pulse in cycle N+1; no O_DONE; all registers and PSR unchanged; ready again at N+2.
REQ-023 I_INSTR_VALID held high for 10 cycles with a new instruction each cycle -> exactly 3 handshakes (at cycles 0, 4 and 8).
REQ-024 I_RESET pulsed during EXEC of ADD R6,R7 -> R6 stays 0, PSR=0, O_DONE never pulses, ready=1 after release.
